hazard_ctrl_mc: RTL and testbench
=================================

# hazard_ctrl_mc

Parametrised pipeline hazard controller for the five-stage RV64I core: operand forwarding into Execute, load-use interlock, branch/jump flush, and stall/bubble control for a multi-cycle Execute unit (iterative mul/div) and a wait-capable data memory. It is the core's only source of per-stage stall and flush signals. It also keeps saturating performance counters for stall cycles and control-flow flushes.

## Interface
- REG_AW, default 5: register-address width.
- CNT_W, default 32: performance-counter width.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- Rs1_D, Rs2_D  in  REG_AW  Decode source registers.
- Rs1_E, Rs2_E, Rd_E  in  REG_AW  Execute source and destination registers.
- ResultSrc_E  in  2  2'b01 marks a load in Execute.
- PCSrc_E  in  1  taken branch or jump resolved in Execute.
- MulDiv_E  in  1  Execute holds a multi-cycle op.
- McDone  in  1  one-cycle pulse from the multi-cycle unit: result ready.
- Rd_M, Rd_W  in  REG_AW  Memory and Writeback destination registers.
- RegWrite_M, RegWrite_W  in  1  write enables.
- DMemReady_M  in  1  data memory has completed the access in Memory.
- CntClear  in  1  synchronous counter clear.
- ForwardA_E, ForwardB_E  out  2  00 regfile, 01 from W, 10 from M.
- Stall_F, Stall_D, Stall_E, Stall_M  out  1  hold the stage register.
- Flush_D, Flush_E, Flush_M, Flush_W  out  1  load a bubble into the stage register.
- McStart_E  out  1  one-cycle launch pulse to the multi-cycle unit.
- StallCycles, FlushCount  out  CNT_W  saturating counters.

## Operation
- Forwarding is combinational, per operand. M has priority over W, then no forwarding. A match requires equal addresses, the stage's RegWrite asserted, and a source register that is not x0.
- `freeze` = !DMemReady_M. While frozen: Stall_F, Stall_D, Stall_E and Stall_M are all 1; Flush_W=1; every other flush is 0; McStart_E=0.
- Multi-cycle FSM has three states: IDLE, BUSY and DONE.
  - IDLE: if MulDiv_E and not frozen, assert McStart_E and go to BUSY. While MulDiv_E is set, assert `mcStall`.
  - BUSY: assert `mcStall`. On McDone, go to IDLE if not frozen, otherwise go to DONE.
  - DONE: assert `mcStall` only while frozen. Go to IDLE on the first unfrozen cycle.
  - In BUSY, `mcStall` drops in the cycle McDone arrives, provided the block is not frozen.
- `mcStall` (not frozen) gives Stall_F = Stall_D = Stall_E = 1 and Flush_M = 1. Stall_M = 0.
- Load-use: `lwStall` = ResultSrc_E==01 && Rd_E!=0 && (Rs1_D==Rd_E || Rs2_D==Rd_E).
- Priority, highest first: freeze > mcStall > PCSrc_E > lwStall.
  - PCSrc_E (effective): Flush_D = Flush_E = 1 and no F/D stall, so the redirect is never lost.
  - lwStall (effective): Stall_F = Stall_D = 1 and Flush_E = 1.
  - A stalled stage is never flushed in the same cycle.
- StallCycles increments on every cycle with Stall_F=1. FlushCount increments on every cycle with an effective PCSrc_E flush.
- Both counters saturate at all-ones. CntClear zeroes both and takes priority over increment.
- A McDone pulse outside BUSY is ignored.

## Timing
- Reset: FSM IDLE, counters 0. With idle inputs (DMemReady_M=1, everything else 0), every stall, flush and McStart_E output is 0 and both Forward outputs are 00.
- All stall, flush and forward outputs are combinational from the current inputs and state. There is no added latency.
- McStart_E is asserted for exactly one cycle per multi-cycle op: the first unfrozen cycle in which the op is in E.
- Mid-operation reset returns the FSM to IDLE immediately. Any in-flight McDone is ignored.
- A back-to-back multi-cycle op reaches E in IDLE after release and launches a new McStart_E.

## Test plan
- Forwarding: Rs1_E=5 matching both Rd_M=5 and Rd_W=5, both RegWrite=1 -> ForwardA_E=10. Same with Rs1_E=0 -> 00.
- Load-use: ResultSrc_E=01, Rd_E=7, Rs2_D=7 -> Stall_F=Stall_D=Flush_E=1 for one cycle. StallCycles advances by 1.
- Branch against load-use: PCSrc_E=1 together with a load-use match -> Flush_D=Flush_E=1, Stall_F=0. FlushCount advances by 1.
- Mul/div: MulDiv_E=1, McDone after 4 cycles -> one McStart_E pulse, then 4 cycles of Stall_F/D/E=1 with Flush_M=1, release in the McDone cycle.
- McDone during memory wait: McDone arrives while DMemReady_M=0 for 3 cycles -> FSM goes to DONE, full freeze with Flush_W=1, release on the first ready cycle.
- Counters: force StallCycles to all-ones, then keep stalling -> holds all-ones. CntClear=1 together with a stall -> StallCycles=0.

Source files
------------

// File: rtl/hazard_ctrl_mc.sv
// Pipeline hazard controller: operand forwarding, load-use interlock, branch flush,
// multi-cycle Execute and data-memory wait handling, plus saturating perf counters.
module hazard_ctrl_mc #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] Rs1_D,
    input  logic [REG_AW-1:0] Rs2_D,
    input  logic [REG_AW-1:0] Rs1_E,
    input  logic [REG_AW-1:0] Rs2_E,
    input  logic [REG_AW-1:0] Rd_E,
    input  logic [1:0]        ResultSrc_E,
    input  logic              PCSrc_E,
    input  logic              MulDiv_E,
    input  logic              McDone,
    input  logic [REG_AW-1:0] Rd_M,
    input  logic [REG_AW-1:0] Rd_W,
    input  logic              RegWrite_M,
    input  logic              RegWrite_W,
    input  logic              DMemReady_M,
    input  logic              CntClear,
    output logic [1:0]        ForwardA_E,
    output logic [1:0]        ForwardB_E,
    output logic              Stall_F,
    output logic              Stall_D,
    output logic              Stall_E,
    output logic              Stall_M,
    output logic              Flush_D,
    output logic              Flush_E,
    output logic              Flush_M,
    output logic              Flush_W,
    output logic              McStart_E,
    output logic [CNT_W-1:0]  StallCycles,
    output logic [CNT_W-1:0]  FlushCount
);

    typedef enum logic [1:0] {
        MC_IDLE = 2'd0,
        MC_BUSY = 2'd1,
        MC_DONE = 2'd2
    } mc_state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    mc_state_t state, state_nxt;
    logic      freeze;
    logic      mc_stall;
    logic      lw_stall;
    logic      br_flush;

    // Memory stage has priority over writeback: it holds the younger value.
    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs);
        if (rs != '0 && RegWrite_M && rs == Rd_M)
            return 2'b10;
        else if (rs != '0 && RegWrite_W && rs == Rd_W)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign ForwardA_E = fwd_sel(Rs1_E);
    assign ForwardB_E = fwd_sel(Rs2_E);

    assign freeze   = !DMemReady_M;
    assign lw_stall = (ResultSrc_E == 2'b01) && (Rd_E != '0) &&
                      ((Rs1_D == Rd_E) || (Rs2_D == Rd_E));

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours; combinational blocks use blocking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= MC_IDLE;
        else
            state <= state_nxt;
    end

    // DONE parks a finished result while memory still holds the pipeline.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can
        // leave one unassigned and infer a latch.
        state_nxt = state;
        mc_stall  = 1'b0;
        McStart_E = 1'b0;
        case (state)
            MC_IDLE: begin
                mc_stall = MulDiv_E;
                if (MulDiv_E && !freeze) begin
                    McStart_E = 1'b1;
                    state_nxt = MC_BUSY;
                end
            end
            MC_BUSY: begin
                mc_stall = !(McDone && !freeze);
                if (McDone)
                    state_nxt = freeze ? MC_DONE : MC_IDLE;
            end
            MC_DONE: begin
                mc_stall = freeze;
                if (!freeze)
                    state_nxt = MC_IDLE;
            end
            default: state_nxt = MC_IDLE;
        endcase
    end

    assign br_flush = !freeze && !mc_stall && PCSrc_E;

    always_comb begin
        Stall_F = 1'b0;
        Stall_D = 1'b0;
        Stall_E = 1'b0;
        Stall_M = 1'b0;
        Flush_D = 1'b0;
        Flush_E = 1'b0;
        Flush_M = 1'b0;
        Flush_W = 1'b0;
        if (freeze) begin
            Stall_F = 1'b1;
            Stall_D = 1'b1;
            Stall_E = 1'b1;
            Stall_M = 1'b1;
            Flush_W = 1'b1;
        end else if (mc_stall) begin
            Stall_F = 1'b1;
            Stall_D = 1'b1;
            Stall_E = 1'b1;
            Flush_M = 1'b1;
        end else if (PCSrc_E) begin
            Flush_D = 1'b1;
            Flush_E = 1'b1;
        end else if (lw_stall) begin
            Stall_F = 1'b1;
            Stall_D = 1'b1;
            Flush_E = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            StallCycles <= '0;
            FlushCount  <= '0;
        end else if (CntClear) begin
            StallCycles <= '0;
            FlushCount  <= '0;
        end else begin
            if (Stall_F && StallCycles != '1)
                StallCycles <= StallCycles + CNT_ONE;
            if (br_flush && FlushCount != '1)
                FlushCount <= FlushCount + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Directed bench for hazard_ctrl_mc: forwarding, interlocks, multi-cycle FSM,
// memory freeze, reset, and counter saturation (4-bit counters).
module tb_hazard_ctrl_mc;

    localparam int REG_AW = 5;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [REG_AW-1:0] Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W;
    logic [1:0]        ResultSrc_E;
    logic              PCSrc_E, MulDiv_E, McDone;
    logic              RegWrite_M, RegWrite_W, DMemReady_M, CntClear;
    logic [1:0]        ForwardA_E, ForwardB_E;
    logic              Stall_F, Stall_D, Stall_E, Stall_M;
    logic              Flush_D, Flush_E, Flush_M, Flush_W;
    logic              McStart_E;
    logic [CNT_W-1:0]  StallCycles, FlushCount;

    int checks = 0;
    int errors = 0;

    hazard_ctrl_mc #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E), .Rd_E(Rd_E),
        .ResultSrc_E(ResultSrc_E), .PCSrc_E(PCSrc_E), .MulDiv_E(MulDiv_E),
        .McDone(McDone), .Rd_M(Rd_M), .Rd_W(Rd_W),
        .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W),
        .DMemReady_M(DMemReady_M), .CntClear(CntClear),
        .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
        .Stall_F(Stall_F), .Stall_D(Stall_D), .Stall_E(Stall_E), .Stall_M(Stall_M),
        .Flush_D(Flush_D), .Flush_E(Flush_E), .Flush_M(Flush_M), .Flush_W(Flush_W),
        .McStart_E(McStart_E), .StallCycles(StallCycles), .FlushCount(FlushCount)
    );

    always #5 clk = ~clk;

    wire [3:0] stalls  = {Stall_F, Stall_D, Stall_E, Stall_M};
    wire [3:0] flushes = {Flush_D, Flush_E, Flush_M, Flush_W};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Checks stalls {F,D,E,M}, flushes {D,E,M,W} and the launch pulse together.
    task automatic check_ctl(input string tag, input logic [3:0] st, input logic [3:0] fl,
                             input logic mc);
        check({tag, "_stall"}, 32'(stalls), 32'(st));
        check({tag, "_flush"}, 32'(flushes), 32'(fl));
        check({tag, "_mcstart"}, 32'(McStart_E), 32'(mc));
    endtask

    task automatic idle_inputs();
        Rs1_D = '0; Rs2_D = '0; Rs1_E = '0; Rs2_E = '0; Rd_E = '0;
        Rd_M = '0; Rd_W = '0; ResultSrc_E = 2'b00;
        PCSrc_E = 1'b0; MulDiv_E = 1'b0; McDone = 1'b0;
        RegWrite_M = 1'b0; RegWrite_W = 1'b0; DMemReady_M = 1'b1; CntClear = 1'b0;
    endtask

    task automatic set_lw();
        ResultSrc_E = 2'b01; Rd_E = 5'd7; Rs2_D = 5'd7;
    endtask

    // Inputs change just after a falling edge; checks land 1 ns later.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    initial begin
        // ---------------- reset ----------------
        rst_n = 1'b0;
        idle_inputs();
        #1;
        check_ctl("reset", 4'b0000, 4'b0000, 1'b0);
        check("reset_fwdA", 32'(ForwardA_E), 32'd0);
        check("reset_fwdB", 32'(ForwardB_E), 32'd0);
        check("reset_stallcnt", 32'(StallCycles), 32'd0);
        check("reset_flushcnt", 32'(FlushCount), 32'd0);
        next_cycle();
        rst_n = 1'b1;
        McDone = 1'b1;                      // stray McDone in IDLE does nothing
        #1;
        check_ctl("stray_mcdone", 4'b0000, 4'b0000, 1'b0);
        next_cycle();
        McDone = 1'b0;

        // ---------------- forwarding ----------------
        Rs1_E = 5'd5; Rs2_E = 5'd5; Rd_M = 5'd5; Rd_W = 5'd5;
        RegWrite_M = 1'b1; RegWrite_W = 1'b1;
        #1;
        check("fwd_m_priority", 32'(ForwardA_E), 32'd2);
        RegWrite_M = 1'b0;
        #1;
        check("fwd_w_only", 32'(ForwardB_E), 32'd1);
        RegWrite_M = 1'b1; Rd_M = 5'd6;
        #1;
        check("fwd_m_addr_miss", 32'(ForwardA_E), 32'd1);
        Rs1_E = 5'd0; Rd_M = 5'd0; Rd_W = 5'd0;
        #1;
        check("fwd_x0", 32'(ForwardA_E), 32'd0);
        next_cycle();
        idle_inputs();

        // ---------------- load-use ----------------
        ResultSrc_E = 2'b01; Rd_E = 5'd0; Rs1_D = 5'd0;
        #1;
        check_ctl("lw_rd_x0", 4'b0000, 4'b0000, 1'b0);
        set_lw();
        #1;
        check_ctl("lw_stall", 4'b1100, 4'b0100, 1'b0);
        next_cycle();
        idle_inputs();
        #1;
        check("lw_stallcnt", 32'(StallCycles), 32'd1);
        check_ctl("lw_release", 4'b0000, 4'b0000, 1'b0);
        next_cycle();

        // ---------------- branch beats load-use ----------------
        set_lw();
        PCSrc_E = 1'b1;
        #1;
        check_ctl("br_over_lw", 4'b0000, 4'b1100, 1'b0);
        next_cycle();
        idle_inputs();
        #1;
        check("br_flushcnt", 32'(FlushCount), 32'd1);
        check("br_stallcnt", 32'(StallCycles), 32'd1);
        next_cycle();

        // ---------------- mul/div, McDone after 4 cycles ----------------
        MulDiv_E = 1'b1;
        #1;
        check_ctl("mc_launch", 4'b1110, 4'b0010, 1'b1);
        for (int i = 1; i <= 3; i++) begin
            next_cycle();
            PCSrc_E = (i == 2);             // a branch cannot overtake the mul stall
            #1;
            check_ctl($sformatf("mc_busy%0d", i), 4'b1110, 4'b0010, 1'b0);
        end
        next_cycle();
        PCSrc_E = 1'b0;
        McDone = 1'b1;
        #1;
        check_ctl("mc_release", 4'b0000, 4'b0000, 1'b0);
        next_cycle();
        idle_inputs();
        #1;
        check_ctl("mc_after", 4'b0000, 4'b0000, 1'b0);
        check("mc_stallcnt", 32'(StallCycles), 32'd5);
        check("mc_flushcnt", 32'(FlushCount), 32'd1);
        next_cycle();

        // ---------------- McDone during memory wait ----------------
        MulDiv_E = 1'b1;
        #1;
        check_ctl("mw_launch", 4'b1110, 4'b0010, 1'b1);
        next_cycle();
        #1;
        check_ctl("mw_busy", 4'b1110, 4'b0010, 1'b0);
        next_cycle();
        DMemReady_M = 1'b0; McDone = 1'b1;
        #1;
        check_ctl("mw_freeze0", 4'b1111, 4'b0001, 1'b0);
        next_cycle();
        McDone = 1'b0; PCSrc_E = 1'b1;      // redirect is held, not counted
        #1;
        check_ctl("mw_freeze1", 4'b1111, 4'b0001, 1'b0);
        next_cycle();
        PCSrc_E = 1'b0;
        #1;
        check_ctl("mw_freeze2", 4'b1111, 4'b0001, 1'b0);
        next_cycle();
        DMemReady_M = 1'b1;                 // op still in E: DONE releases, no relaunch
        #1;
        check_ctl("mw_release", 4'b0000, 4'b0000, 1'b0);
        next_cycle();
        idle_inputs();
        #1;
        check("mw_stallcnt", 32'(StallCycles), 32'd10);
        check("mw_flushcnt", 32'(FlushCount), 32'd1);
        check_ctl("mw_idle", 4'b0000, 4'b0000, 1'b0);
        next_cycle();

        // ---------------- reset mid-operation ----------------
        MulDiv_E = 1'b1;
        #1;
        check_ctl("rst_launch", 4'b1110, 4'b0010, 1'b1);
        next_cycle();
        #1;
        check_ctl("rst_busy", 4'b1110, 4'b0010, 1'b0);
        rst_n = 1'b0;
        MulDiv_E = 1'b0;
        #1;
        check("rst_mid_stallcnt", 32'(StallCycles), 32'd0);
        next_cycle();
        rst_n = 1'b1;
        MulDiv_E = 1'b1;
        #1;
        check_ctl("rst_relaunch", 4'b1110, 4'b0010, 1'b1);
        next_cycle();
        McDone = 1'b1;
        #1;
        check_ctl("b2b_done0", 4'b0000, 4'b0000, 1'b0);
        next_cycle();
        McDone = 1'b0;                      // next mul/div op arrives directly
        #1;
        check_ctl("b2b_launch", 4'b1110, 4'b0010, 1'b1);
        next_cycle();
        McDone = 1'b1;
        #1;
        check_ctl("b2b_done1", 4'b0000, 4'b0000, 1'b0);
        next_cycle();
        idle_inputs();
        #1;
        check("b2b_stallcnt", 32'(StallCycles), 32'd2);
        check("b2b_flushcnt", 32'(FlushCount), 32'd0);

        // ---------------- counter saturation and clear ----------------
        set_lw();
        for (int i = 0; i < 20; i++) next_cycle();
        #1;
        check("sat_stallcnt", 32'(StallCycles), 32'hF);
        CntClear = 1'b1;
        next_cycle();
        #1;
        check("clr_stallcnt", 32'(StallCycles), 32'd0);
        check("clr_flushcnt", 32'(FlushCount), 32'd0);
        CntClear = 1'b0;
        next_cycle();
        #1;
        check("post_clr_stallcnt", 32'(StallCycles), 32'd1);
        idle_inputs();
        next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
